// File: rtl/mem_align_ctrl.sv
// mem_align_ctrl -- EX/MEM memory-port stage with misaligned-access handling.
//
// Captures the EX-stage memory request on each enabled clock edge and drives the
// data-RAM port for the following cycle. Stores are lane-shifted into the word
// and given byte enables. Accesses that cross a word boundary are either split
// into two word writes (stores, optional build) or flagged as a fault.
//
// Build option:
//   MISALIGNED_STORE_SPLIT_EN  defined   -> spanning stores are split over two
//                                           cycles (SPLIT2 state, StallReq=1).
//                              undefined -> spanning stores fault like loads;
//                                           SPLIT2 is never entered.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   en, clear           stage enable (0 = hold) and flush (capture a bubble)
//   AddrE, StoreDataE   byte address and right-aligned store data from EX
//   StoreTypeE          0 none, 1 SB, 2 SH, 3 SW
//   LoadTypeE           0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU
//   A, WD, WE           data-RAM address, lane-shifted write data, byte enables
//   LoadTypeM           registered load type for load extension
//   StallReq            combinational freeze request while part 2 is pending
//   AlignFaultM         registered misaligned-access fault
module mem_align_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        clear,
    input  logic [31:0] AddrE,
    input  logic [31:0] StoreDataE,
    input  logic [1:0]  StoreTypeE,
    input  logic [2:0]  LoadTypeE,
    output logic [31:0] A,
    output logic [31:0] WD,
    output logic [3:0]  WE,
    output logic [2:0]  LoadTypeM,
    output logic        StallReq,
    output logic        AlignFaultM
);

    typedef enum logic [0:0] {StIdle, StSplit2} state_e;

    state_e      state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] wd_q, wd_d;
    logic [3:0]  we_q, we_d;
    logic [2:0]  lt_q, lt_d;
    logic        fault_q, fault_d;
    // Second half of a split store, held until the pipeline lets it out.
    logic [31:0] p2_a_q, p2_a_d;
    logic [31:0] p2_wd_q, p2_wd_d;
    logic [3:0]  p2_we_q, p2_we_d;

    // Request decode.
    logic [1:0]  off;
    logic [2:0]  st_sz, ld_sz, sz;
    logic [2:0]  end_pos;
    logic        is_store, is_load, spans;
    logic [3:0]  size_mask;
    logic [31:0] wd_shl;

    assign off      = AddrE[1:0];
    assign is_store = (StoreTypeE != 2'd0);
    assign is_load  = !is_store && (LoadTypeE != 3'd0);

    always_comb begin
        st_sz = 3'd4;
        unique case (StoreTypeE)
            2'd1:    st_sz = 3'd1;
            2'd2:    st_sz = 3'd2;
            default: st_sz = 3'd4;
        endcase
        ld_sz = 3'd1;
        case (LoadTypeE)
            3'd2, 3'd5: ld_sz = 3'd2;
            3'd3:       ld_sz = 3'd4;
            default:    ld_sz = 3'd1;
        endcase
    end

    assign sz        = is_store ? st_sz : ld_sz;
    assign end_pos   = {1'b0, off} + sz;      // max 3 + 4 = 7, fits 3 bits
    assign spans     = (end_pos > 3'd4);
    // 4'd1 << 4 wraps to 0 in 4 bits, so the mask for sz=4 comes out 4'hF.
    assign size_mask = (4'd1 << sz) - 4'd1;
    assign wd_shl    = StoreDataE << {off, 3'b000};

`ifdef MISALIGNED_STORE_SPLIT_EN
    logic [31:0] word_base;
    logic [2:0]  rem_bytes;
    logic [5:0]  shr_amt;

    assign word_base = {AddrE[31:2], 2'b00};
    assign rem_bytes = end_pos - 3'd4;
    // Only used when spanning, so off != 0 and the shift is 8..24.
    assign shr_amt   = 6'd32 - {1'b0, off, 3'b000};
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        wd_d    = wd_q;
        we_d    = 4'b0000;   // enables only live for the cycle they are issued
        lt_d    = lt_q;
        fault_d = fault_q;
        p2_a_d  = p2_a_q;
        p2_wd_d = p2_wd_q;
        p2_we_d = p2_we_q;

        case (state_q)
            StIdle: begin
                if (en) begin
                    a_d     = AddrE;
                    wd_d    = 32'h0;
                    lt_d    = 3'd0;
                    fault_d = 1'b0;
                    if (clear) begin
                        a_d = 32'h0;
                    end else if (is_store) begin
                        if (!spans) begin
                            we_d = size_mask << off;
                            wd_d = wd_shl;
                        end else begin
`ifdef MISALIGNED_STORE_SPLIT_EN
                            a_d     = word_base;
                            we_d    = 4'hF << off;
                            wd_d    = wd_shl;
                            p2_a_d  = word_base + 32'd4;
                            p2_we_d = (4'd1 << rem_bytes) - 4'd1;
                            p2_wd_d = StoreDataE >> shr_amt;
                            state_d = StSplit2;
`else
                            fault_d = 1'b1;
`endif
                        end
                    end else if (is_load) begin
                        if (spans) begin
                            fault_d = 1'b1;
                        end else begin
                            lt_d = LoadTypeE;
                        end
                    end
                end
            end
            StSplit2: begin
                // Part 1 is already committed, so clear is not honoured here.
                if (en) begin
                    a_d     = p2_a_q;
                    wd_d    = p2_wd_q;
                    we_d    = p2_we_q;
                    lt_d    = 3'd0;
                    fault_d = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= 32'h0;
            wd_q    <= 32'h0;
            we_q    <= 4'b0000;
            lt_q    <= 3'd0;
            fault_q <= 1'b0;
            p2_a_q  <= 32'h0;
            p2_wd_q <= 32'h0;
            p2_we_q <= 4'b0000;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            wd_q    <= wd_d;
            we_q    <= we_d;
            lt_q    <= lt_d;
            fault_q <= fault_d;
            p2_a_q  <= p2_a_d;
            p2_wd_q <= p2_wd_d;
            p2_we_q <= p2_we_d;
        end
    end

    assign A           = a_q;
    assign WD          = wd_q;
    assign WE          = we_q;
    assign LoadTypeM   = lt_q;
    assign AlignFaultM = fault_q;
    // Never asserted in the non-split build since SPLIT2 is unreachable there.
    assign StallReq    = (state_q == StSplit2);

endmodule

// File: doc/mem_align_ctrl.md
MEM_ALIGN_CTRL -- requirements
Module: mem_align_ctrl

Interface
REQ-001 SHALL have the following ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  segment enable from the hazard unit; 0 = hold.
- clear  in  1  flush: the instruction being captured becomes a bubble.
- AddrE  in  32  byte address from the ALU.
- StoreDataE  in  32  store data, right-aligned.
- StoreTypeE  in  2  0 = none, 1 = SB, 2 = SH, 3 = SW.
- LoadTypeE  in  3  0 = none, 1 = LB, 2 = LH, 3 = LW, 4 = LBU, 5 = LHU.
- A  out  32  data-RAM port A byte address; bits [1:0] are passed to the write-back stage as the byte select.
- WD  out  32  data-RAM write data, lane-shifted.
- WE  out  4  data-RAM byte write enables.
- LoadTypeM  out  3  registered load type for the load-extension logic.
- StallReq  out  1  combinational request to freeze PC/IF/ID/EX.
- AlignFaultM  out  1  registered misaligned-access fault flag.

Function
REQ-002 SHALL be a registered EX/MEM memory-port stage: inputs captured at a posedge with en=1 appear on the outputs for the following cycle.
REQ-003 SHALL compute off = AddrE[1:0] and size sz = 1, 2 or 4 bytes. An access spans two words when off+sz > 4: SH with off=3, or SW with off≠0.
REQ-004 For a non-spanning store, SHALL drive:
- A = AddrE.
- WE = ones in lanes off..off+sz-1.
- WD = StoreDataE << 8*off.
REQ-005 SHALL implement FSM states IDLE and SPLIT2. The reset state is IDLE.
REQ-006 In IDLE, on capture (en=1, clear=0) of a spanning store, the FSM SHALL:
- drive part 1: A = {AddrE[31:2],2'b00}, WE = lanes off..3, WD = StoreDataE << 8*off;
- latch part 2: A = {AddrE[31:2],2'b00}+4, WE = lanes 0..off+sz-5, WD = StoreDataE >> 8*(4-off);
- go to SPLIT2.
REQ-007 StallReq SHALL be 1 exactly while state=SPLIT2. Inputs are ignored in SPLIT2.
REQ-008 In SPLIT2 with en=1, SHALL drive the latched part 2 on the next cycle and return to IDLE. The following instruction is captured one cycle after that.
REQ-009 In SPLIT2 with en=0, SHALL hold state and latched data. The registered outputs hold their values except WE, which SHALL read 4'b0000.
REQ-010 clear in SPLIT2 SHALL be ignored, because part 1 is already committed and part 2 must complete.
REQ-011 A capture with clear=1 SHALL produce a bubble: WE = 0, LoadTypeM = 0, AlignFaultM = 0, A = 0, WD = 0.
REQ-012 A capture with en=0 in IDLE SHALL hold all registered outputs except WE, which reads 0.
REQ-013 Loads SHALL never write: WE = 0, A = AddrE, LoadTypeM = LoadTypeE.
REQ-014 A spanning load (LH/LHU with off=3, or LW with off≠0) SHALL set AlignFaultM = 1 for one cycle and force LoadTypeM = 0.
REQ-015 StoreTypeE≠0 together with LoadTypeE≠0 SHALL be treated as the store, with LoadTypeM = 0.
REQ-016 Address arithmetic SHALL be 32-bit modulo. Part 2 of an access at word 0xFFFFFFFC wraps to A = 0x00000000.

Reset
REQ-017 When rst=1 at a posedge, the block SHALL set state = IDLE and A = WD = 0, WE = 0, LoadTypeM = 0, AlignFaultM = 0, StallReq = 0.
REQ-018 rst SHALL take priority over en and clear. A reset in SPLIT2 abandons part 2.

Configuration
REQ-019 Macro MISALIGNED_STORE_SPLIT_EN:
- When defined, spanning stores SHALL be split per REQ-006..010.
- When undefined, SPLIT2 is unreachable and StallReq is constant 0. A spanning store SHALL then give WE = 0 and AlignFaultM = 1 for one cycle, exactly as a spanning load.
- Non-spanning behaviour SHALL be identical in both builds.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- SB, AddrE = 0x102, data 0x000000AB -> next cycle A = 0x102, WE = 0100, WD = 0x00AB0000, StallReq = 0.
- SW, AddrE = 0x101, data 0x11223344 (split build):
  - cycle 1: A = 0x100, WE = 1110, WD = 0x22334400, StallReq = 1;
  - cycle 2: A = 0x104, WE = 0001, WD = 0x00000011, StallReq = 0.
- Same SW with en=0 held for 2 cycles while in SPLIT2 -> WE = 0000 and StallReq = 1 during the hold; part 2 is issued once en returns to 1.
- LW, AddrE = 0x202 -> AlignFaultM = 1 for one cycle, WE = 0, LoadTypeM = 0. The non-split build also faults on SW at 0x101.
- rst asserted in SPLIT2 -> next cycle WE = 0, StallReq = 0, state IDLE, and no part-2 write.
- SH, AddrE = 0xFFFFFFFF, data 0xBEEF -> part 1 at A = 0xFFFFFFFC with WE = 1000, WD = 0xEF000000; part 2 at A = 0x00000000 with WE = 0001, WD = 0x000000BE.
